// File: rtl/i2s_audio_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : i2s_audio_transmitter
// Purpose  : Buffers signed mono samples in a small FIFO and sends each one
//            on both channels of a Philips I2S link. The bit clock and word
//            select are derived from the system clock. Sticky flags report
//            dropped samples (overflow) and frames started without data
//            (underflow).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous reset, active low
//   audio_in       in   [DATA_WIDTH] signed sample
//   data_in_valid  in   single-cycle strobe qualifying audio_in
//   clear_flags    in   synchronous clear of overflow/underflow
//   i2s_bclk       out  bit clock, period 2*CLK_DIV clk cycles
//   i2s_lrck       out  word select, 0 = left, 1 = right
//   i2s_sdata      out  serial data, MSB first, one-bclk delayed
//   fifo_level     out  [$clog2(FIFO_DEPTH+1)] FIFO occupancy
//   overflow       out  sticky, sample dropped on a full FIFO
//   underflow      out  sticky, frame started with an empty FIFO
// ============================================================================
module i2s_audio_transmitter #(
  parameter int DATA_WIDTH  = 32,
  parameter int SAMPLE_BITS = 24,
  parameter int CLK_DIV     = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             audio_in,
  input  logic                              data_in_valid,
  input  logic                              clear_flags,
  output logic                              i2s_bclk,
  output logic                              i2s_lrck,
  output logic                              i2s_sdata,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH+1);

  // Clock divider / frame state
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   bclk_q, bclk_d;
  logic [5:0]             bit_cnt_q, bit_cnt_d;
  logic                   lrck_q, lrck_d;
  logic                   sdata_q, sdata_d;
  logic [SAMPLE_BITS-1:0] word_q, word_d;
  logic                   first_q, first_d;

  // FIFO state
  logic [SAMPLE_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;

  // Combinational helpers
  logic                   w_tick;
  logic                   w_fall;
  logic                   w_wrap;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic [SAMPLE_BITS-1:0] w_sample;
  logic [4:0]             w_pos;
  logic [4:0]             w_idx;
  logic [31:0]            w_word_ext;

  // Truncate to the top SAMPLE_BITS; the discarded LSBs are intentionally
  // unused.
  assign w_sample = audio_in[DATA_WIDTH-1 -: SAMPLE_BITS];

  generate
    if (DATA_WIDTH > SAMPLE_BITS) begin : g_lsbs
      logic w_unused_lsbs;
      assign w_unused_lsbs = ^audio_in[DATA_WIDTH-SAMPLE_BITS-1:0];
    end
  endgenerate

  always_comb begin
    w_tick     = (div_q == DIV_W'(CLK_DIV-1));
    div_d      = w_tick ? '0 : div_q + 1'b1;
    bclk_d     = w_tick ? ~bclk_q : bclk_q;
    w_fall     = w_tick & bclk_q;
    bit_cnt_d  = w_fall ? bit_cnt_q + 6'd1 : bit_cnt_q;
    w_wrap     = w_fall && (bit_cnt_q == 6'd63);

    w_empty    = (level_q == '0);
    w_full     = (level_q == LVL_W'(FIFO_DEPTH));
    w_pop      = w_wrap & ~w_empty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
    w_push     = data_in_valid & (~w_full | w_pop);

    word_d     = word_q;
    if (w_wrap) begin
      word_d = w_pop ? mem_q[rd_ptr_q] : '0;
    end

    wr_ptr_d   = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    level_d    = level_q;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Set conditions take priority over clear_flags.
    ovf_d = ovf_q;
    if (data_in_valid & w_full & ~w_pop) begin
      ovf_d = 1'b1;
    end else if (clear_flags) begin
      ovf_d = 1'b0;
    end

    // The first wrap after reset ends the free-running startup frame and
    // never counts as an underflow.
    unf_d = unf_q;
    if (w_wrap & w_empty & ~first_q) begin
      unf_d = 1'b1;
    end else if (clear_flags) begin
      unf_d = 1'b0;
    end
    first_d = w_wrap ? 1'b0 : first_q;

    // Outputs are registered from next-state values so they move exactly on
    // falling events. Slot p carries word[SAMPLE_BITS-p] for 1..SAMPLE_BITS,
    // giving the one-bclk delay after each lrck edge.
    lrck_d     = bit_cnt_d[5];
    w_pos      = bit_cnt_d[4:0];
    w_word_ext = {{(32-SAMPLE_BITS){1'b0}}, word_d};
    w_idx      = 5'(SAMPLE_BITS) - w_pos;
    sdata_d    = ((w_pos != 5'd0) && (w_pos <= 5'(SAMPLE_BITS))) ? w_word_ext[w_idx] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q     <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= '0;
      lrck_q    <= 1'b0;
      sdata_q   <= 1'b0;
      word_q    <= '0;
      first_q   <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      lrck_q    <= lrck_d;
      sdata_q   <= sdata_d;
      word_q    <= word_d;
      first_q   <= first_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= w_sample;
    end
  end

  assign i2s_bclk   = bclk_q;
  assign i2s_lrck   = lrck_q;
  assign i2s_sdata  = sdata_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_audio_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_audio_transmitter
// Purpose  : Directed self-checking bench for i2s_audio_transmitter with
//            CLK_DIV=2, SAMPLE_BITS=24, FIFO_DEPTH=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_audio_transmitter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] audio_in = '0;
  logic        data_in_valid = 1'b0;
  logic        clear_flags = 1'b0;
  logic        i2s_bclk, i2s_lrck, i2s_sdata, overflow, underflow;
  logic [2:0]  fifo_level;

  int vecs  = 0;
  int fails = 0;

  i2s_audio_transmitter #(
    .DATA_WIDTH (32),
    .SAMPLE_BITS(24),
    .CLK_DIV    (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .audio_in     (audio_in),
    .data_in_valid(data_in_valid),
    .clear_flags  (clear_flags),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected 64-slot frame, slot 0 in bit 63: one delay slot, 24 data bits,
  // 7 padding zeros, repeated for left and right.
  function automatic logic [63:0] frame_of(input logic [23:0] w);
    return {2{1'b0, w, 7'b0}};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [31:0] s);
    audio_in      = s;
    data_in_valid = 1'b1;
    step(1);
    data_in_valid = 1'b0;
  endtask

  // Samples one point per slot for a whole frame (4 clk per slot).
  task automatic check_frame(input string tag, input logic [63:0] exp);
    logic [63:0] sd;
    logic [63:0] lr;
    sd = '0;
    lr = '0;
    for (int s = 0; s < 64; s++) begin
      sd = {sd[62:0], i2s_sdata};
      lr = {lr[62:0], i2s_lrck};
      step(4);
    end
    chk({tag, "_sdata"}, sd, exp);
    chk({tag, "_lrck"}, lr, 64'h00000000_FFFFFFFF);
  endtask

  // Returns just after the clk edge where lrck falls (bit_cnt 63 -> 0).
  task automatic wait_wrap();
    logic prev;
    logic found;
    found = 1'b0;
    prev  = i2s_lrck;
    for (int i = 0; i < 300 && !found; i++) begin
      step(1);
      if (prev && !i2s_lrck) found = 1'b1;
      prev = i2s_lrck;
    end
    chk("wrap_seen", 64'(found), 64'd1);
  endtask

  logic [31:0] burst [6];
  logic [7:0]  bc;

  initial begin
    burst[0] = 32'hA5A5A5FF;
    burst[1] = 32'h5A5A5A00;
    burst[2] = 32'h00000100;
    burst[3] = 32'hFFFFFF00;
    burst[4] = 32'h13579BDF;
    burst[5] = 32'h2468ACE0;

    // Reset and idle
    step(3);
    chk("reset_outputs", 64'({i2s_bclk, i2s_lrck, i2s_sdata, overflow, underflow, fifo_level}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1);
    check_frame("idle_frame0", 64'd0);
    chk("unf_first_wrap_exempt", 64'(underflow), 64'd0);
    bc = '0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      bc = {bc[6:0], i2s_bclk};
    end
    chk("bclk_pattern", 64'(bc), 64'(8'b11001100));
    wait_wrap();
    chk("unf_second_wrap", 64'(underflow), 64'd1);

    // Single MSB-only sample
    pulse(32'h80000000);
    chk("lvl_after_write", 64'(fifo_level), 64'd1);
    wait_wrap();
    chk("lvl_after_pop", 64'(fifo_level), 64'd0);
    check_frame("msb_frame", 64'h40000000_40000000);

    // Truncation of the low byte
    pulse(32'h12345678);
    wait_wrap();
    check_frame("trunc_frame", 64'h091A2B00_091A2B00);

    // Burst of six mid-frame
    step(100);
    for (int i = 0; i < 6; i++) pulse(burst[i]);
    chk("burst_level", 64'(fifo_level), 64'd4);
    chk("burst_overflow", 64'(overflow), 64'd1);
    wait_wrap();
    for (int i = 0; i < 4; i++) check_frame($sformatf("burst_frame%0d", i + 1), frame_of(burst[i][31:8]));
    check_frame("burst_tail_zero", 64'd0);
    clear_flags = 1'b1;
    step(1);
    clear_flags = 1'b0;
    chk("clear_overflow", 64'(overflow), 64'd0);
    chk("clear_underflow", 64'(underflow), 64'd0);

    // Valid on the exact wrap cycle with the FIFO empty
    step(254);
    audio_in      = 32'hC0FFEE11;
    data_in_valid = 1'b1;
    step(1);
    data_in_valid = 1'b0;
    chk("wrapwr_lrck_fell", 64'(i2s_lrck), 64'd0);
    chk("wrapwr_underflow", 64'(underflow), 64'd1);
    chk("wrapwr_level", 64'(fifo_level), 64'd1);
    check_frame("wrapwr_zero_frame", 64'd0);
    check_frame("wrapwr_sample_frame", frame_of(24'hC0FFEE));

    // Reset pulse at slot 40 with three samples queued
    pulse(32'h11111100);
    pulse(32'h22222200);
    pulse(32'h33333300);
    step(158);
    chk("pre_rst_lrck", 64'(i2s_lrck), 64'd1);
    chk("pre_rst_level", 64'(fifo_level), 64'd3);
    rst = 1'b0;
    #1;
    chk("midrst_outputs", 64'({i2s_bclk, i2s_lrck, i2s_sdata, overflow, underflow, fifo_level}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1);
    chk("post_rst_level", 64'(fifo_level), 64'd0);
    check_frame("post_rst_frame0", 64'd0);
    chk("post_rst_unf_exempt", 64'(underflow), 64'd0);
    check_frame("post_rst_frame1", 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
`default_nettype wire
